// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for the pipelined ALU and its combinational core.
package alu_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_MIN  = 3'b010,
      ALU_MAX  = 3'b011,
      ALU_AND  = 3'b100,
      ALU_OR   = 3'b101,
      ALU_XOR  = 3'b110,
      ALU_XNOR = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic cout;
      logic zero;
      logic neg;
      logic ovf;
   } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: 8-op result plus carry/zero/negative/overflow flags.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_e          op,
   input  logic             sgn,
   input  logic             cin,
   output logic [WIDTH-1:0] y,
   output alu_flags_t       flags
);

   localparam int unsigned XW = WIDTH + 1;

   logic [XW-1:0]    sum;
   logic [XW-1:0]    diff;
   logic [WIDTH-1:0] ka;
   logic [WIDTH-1:0] kb;
   logic             a_lt_b;
   logic             b_lt_a;

   // Flipping the MSB turns a two's-complement compare into an unsigned one
   always_comb begin
      sum    = {1'b0, a} + {1'b0, b} + XW'(cin);
      diff   = {1'b0, a} - {1'b0, b} - XW'(cin);
      ka     = {a[WIDTH-1] ^ sgn, a[WIDTH-2:0]};
      kb     = {b[WIDTH-1] ^ sgn, b[WIDTH-2:0]};
      a_lt_b = (ka < kb);
      b_lt_a = (kb < ka);
   end

   always_comb begin
      y     = '0;
      flags = '0;
      case (op)
         ALU_ADD: begin
            y          = sum[WIDTH-1:0];
            flags.cout = sum[WIDTH];
            flags.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            y          = diff[WIDTH-1:0];
            flags.cout = diff[WIDTH];
            flags.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_MIN:  y = b_lt_a ? b : a;
         ALU_MAX:  y = a_lt_b ? b : a;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_XNOR: y = ~(a ^ b);
         default:  y = '0;
      endcase
      flags.zero = (y == '0);
      flags.neg  = y[WIDTH-1];
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready wrapper around alu_core: S1 holds operands, S2 holds result and flags.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   input  logic             sgn,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   alu_op_e          s1_op;
   logic             s1_sgn;
   logic             s1_cin;
   logic             s1_load;
   logic             s2_load;
   logic [WIDTH-1:0] core_y;
   alu_flags_t       core_flags;

   // in_ready follows out_ready combinationally so a draining S2 lets S1 refill without a bubble
   always_comb begin
      s2_load  = s1_valid & (~out_valid | out_ready);
      in_ready = ~s1_valid | s2_load;
      s1_load  = in_valid & in_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Operand registers carry no reset; s1_valid qualifies them
   always_ff @(posedge clk) begin
      if (s1_load && !rst) begin
         s1_a   <= a;
         s1_b   <= b;
         s1_op  <= alu_op_e'(op);
         s1_sgn <= sgn;
         s1_cin <= cin;
      end
   end

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a     (s1_a),
      .b     (s1_b),
      .op    (s1_op),
      .sgn   (s1_sgn),
      .cin   (s1_cin),
      .y     (core_y),
      .flags (core_flags)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         y         <= '0;
         cout      <= 1'b0;
         zero      <= 1'b0;
         neg       <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         if (s2_load) begin
            out_valid <= 1'b1;
            y         <= core_y;
            cout      <= core_flags.cout;
            zero      <= core_flags.zero;
            neg       <= core_flags.neg;
            ovf       <= core_flags.ovf;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=16): directed flag cases, streaming, backpressure, reset.
module tb_alu_pipe;

   typedef struct packed {
      logic [15:0] y;
      logic        cout;
      logic        zero;
      logic        neg;
      logic        ovf;
   } res_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic [2:0]  op;
   logic        sgn;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] y;
   logic        cout;
   logic        zero;
   logic        neg;
   logic        ovf;

   res_t exp_q[$];
   int   n_cmp;
   int   n_bad;

   alu_pipe #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .sgn       (sgn),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .cout      (cout),
      .zero      (zero),
      .neg       (neg),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model built on integer arithmetic
   function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                  input logic [2:0] mop, input logic msg, input logic mcin);
      res_t   r;
      longint ua, ub, sa, sb, t;
      logic [15:0] lo;
      ua = longint'(ma);
      ub = longint'(mb);
      sa = ma[15] ? ua - 65536 : ua;
      sb = mb[15] ? ub - 65536 : ub;
      r  = '0;
      case (mop)
         3'd0: begin
            t = ua + ub + longint'(mcin);
            lo = t[15:0];
            r.y = lo;
            r.cout = (t > 65535);
            t = sa + sb + longint'(mcin);
            r.ovf = (t > 32767) || (t < -32768);
         end
         3'd1: begin
            t = ua - ub - longint'(mcin) + 65536 * 2;
            lo = t[15:0];
            r.y = lo;
            r.cout = (ua < ub + longint'(mcin));
            t = sa - sb - longint'(mcin);
            r.ovf = (t > 32767) || (t < -32768);
         end
         3'd2: r.y = (msg ? (sb < sa) : (ub < ua)) ? mb : ma;
         3'd3: r.y = (msg ? (sa < sb) : (ua < ub)) ? mb : ma;
         3'd4: r.y = ma & mb;
         3'd5: r.y = ma | mb;
         3'd6: r.y = ma ^ mb;
         default: r.y = ~(ma ^ mb);
      endcase
      r.zero = (r.y == 16'h0000);
      r.neg  = r.y[15];
      return r;
   endfunction

   // One clock: drive inputs at negedge, sample DUT just after, then let the posedge happen
   task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [2:0] iop, input logic isg, input logic icin, input logic ordy,
                       output logic acc, output logic ov, output res_t got);
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      op        = iop;
      sgn       = isg;
      cin       = icin;
      out_ready = ordy;
      #1;
      acc = iv && in_ready && !rst;
      ov  = out_valid;
      got = '{y, cout, zero, neg, ovf};
      @(posedge clk);
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      n_cmp++; if (y !== 16'h0000) begin n_bad++; $display("FAIL reset_y: got %h required 0000", y); end
      n_cmp++; if ({cout, zero, neg, ovf} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b required 0000", {cout, zero, neg, ovf}); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
   endtask

   // Directed ADD/SUB/MIN/MAX cases with hand-derived expected results
   task automatic test_directed;
      logic [15:0] va[12]  = '{16'hFFFF, 16'h7FFF, 16'h0001, 16'h0003, 16'h8000, 16'h0005,
                               16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'h1234, 16'h1234};
      logic [15:0] vb[12]  = '{16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'h0001, 16'h0004,
                               16'h0001, 16'h0001, 16'h7FFF, 16'h7FFF, 16'h1234, 16'h1234};
      logic [2:0]  vop[12] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd2, 3'd3};
      logic        vsg[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0};
      logic        vci[12] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1};
      res_t        ve[12]  = '{'{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0},
                               '{16'h8000, 1'b0, 1'b0, 1'b1, 1'b1},
                               '{16'h0003, 1'b0, 1'b0, 1'b0, 1'b0},
                               '{16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0},
                               '{16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1},
                               '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0},
                               '{16'h0001, 1'b0, 1'b0, 1'b0, 1'b0},
                               '{16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0},
                               '{16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0},
                               '{16'h8000, 1'b0, 1'b0, 1'b1, 1'b0},
                               '{16'h1234, 1'b0, 1'b0, 1'b0, 1'b0},
                               '{16'h1234, 1'b0, 1'b0, 1'b0, 1'b0}};
      int   i = 0;
      int   n_out = 0;
      logic acc, ov;
      res_t got, e;
      for (int c = 0; c < 24; c++) begin
         if (i < 12) step(1'b1, va[i], vb[i], vop[i], vsg[i], vci[i], 1'b1, acc, ov, got);
         else        step(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1, acc, ov, got);
         if (acc) begin exp_q.push_back(ve[i]); i++; end
         if (ov) begin
            n_cmp++;
            if (c !== n_out + 2) begin n_bad++; $display("FAIL directed_latency: result %0d at cycle %0d required %0d", n_out, c, n_out + 2); end
            n_cmp++;
            if (exp_q.size() == 0) begin n_bad++; $display("FAIL directed_extra: got y=%h with empty scoreboard", got.y); end
            else begin
               e = exp_q.pop_front();
               if (got !== e) begin n_bad++; $display("FAIL directed_result %0d: got y=%h c%b z%b n%b v%b required y=%h c%b z%b n%b v%b", n_out, got.y, got.cout, got.zero, got.neg, got.ovf, e.y, e.cout, e.zero, e.neg, e.ovf); end
            end
            n_out++;
         end
      end
      n_cmp++; if (n_out !== 12 || exp_q.size() != 0) begin n_bad++; $display("FAIL directed_count: got %0d results required 12", n_out); exp_q.delete(); end
   endtask

   task automatic test_back_to_back;
      logic [2:0]  ops[8] = '{3'd6, 3'd4, 3'd5, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
      logic [15:0] ta[8];
      logic [15:0] tb_v[8];
      logic        ts[8];
      logic        tc[8];
      int   i = 0;
      int   n_out = 0;
      logic acc, ov;
      res_t got, e;
      for (int k = 0; k < 8; k++) begin
         ta[k]   = 16'($urandom);
         tb_v[k] = 16'($urandom);
         ts[k]   = 1'($urandom);
         tc[k]   = 1'($urandom);
      end
      for (int c = 0; c < 16; c++) begin
         if (i < 8) begin
            step(1'b1, ta[i], tb_v[i], ops[i], ts[i], tc[i], 1'b1, acc, ov, got);
            n_cmp++;
            if (acc !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got 0 at cycle %0d required 1", c); end
         end else begin
            step(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1, acc, ov, got);
         end
         if (acc) begin exp_q.push_back(model(ta[i], tb_v[i], ops[i], ts[i], tc[i])); i++; end
         if (ov) begin
            n_cmp++;
            if (c !== n_out + 2) begin n_bad++; $display("FAIL b2b_timing: result %0d at cycle %0d required %0d", n_out, c, n_out + 2); end
            n_cmp++;
            if (exp_q.size() == 0) begin n_bad++; $display("FAIL b2b_extra: got y=%h with empty scoreboard", got.y); end
            else begin
               e = exp_q.pop_front();
               if (got !== e) begin n_bad++; $display("FAIL b2b_result %0d: got %h required %h", n_out, got, e); end
            end
            n_out++;
         end
      end
      n_cmp++; if (n_out !== 8 || exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_count: got %0d results required 8", n_out); exp_q.delete(); end
   endtask

   task automatic test_backpressure;
      logic [15:0] pa[4] = '{16'h1111, 16'hF0F0, 16'h7FFF, 16'h0010};
      logic [15:0] pb[4] = '{16'h2222, 16'h0FF0, 16'h7FFF, 16'h0020};
      logic [2:0]  po[4] = '{3'd0, 3'd6, 3'd1, 3'd3};
      int   i = 0;
      int   n_out = 0;
      logic acc, ov, ordy;
      res_t got, e, held;
      held = '0;
      for (int c = 0; c < 14; c++) begin
         ordy = (c >= 5);
         if (i < 4) step(1'b1, pa[i], pb[i], po[i], 1'b0, 1'b0, ordy, acc, ov, got);
         else       step(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, ordy, acc, ov, got);
         if (c >= 2 && c <= 4) begin
            n_cmp++;
            if (acc !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: accepted at cycle %0d required stall", c); end
            n_cmp++;
            if (ov !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %b at cycle %0d required 1", ov, c); end
            if (c == 2) held = got;
            else begin
               n_cmp++;
               if (got !== held) begin n_bad++; $display("FAIL bp_stable: got %h at cycle %0d required %h", got, c, held); end
            end
         end
         if (acc) begin exp_q.push_back(model(pa[i], pb[i], po[i], 1'b0, 1'b0)); i++; end
         if (ov && ordy) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_bad++; $display("FAIL bp_extra: got y=%h with empty scoreboard", got.y); end
            else begin
               e = exp_q.pop_front();
               if (got !== e) begin n_bad++; $display("FAIL bp_result %0d: got %h required %h", n_out, got, e); end
            end
            n_out++;
         end
      end
      n_cmp++; if (n_out !== 4 || exp_q.size() != 0) begin n_bad++; $display("FAIL bp_count: got %0d results required 4", n_out); exp_q.delete(); end
   endtask

   task automatic test_reset_midstream;
      int   n_out = 0;
      logic acc, ov;
      res_t got, e;
      step(1'b1, 16'hAAAA, 16'h5555, 3'd5, 1'b0, 1'b0, 1'b0, acc, ov, got);
      step(1'b1, 16'h0F0F, 16'h00FF, 3'd4, 1'b0, 1'b0, 1'b0, acc, ov, got);
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 16'h1234, 16'h1111, 3'd0, 1'b0, 1'b0, 1'b1, acc, ov, got);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b required 0", out_valid); end
      n_cmp++; if (y !== 16'h0000) begin n_bad++; $display("FAIL rstmid_y: got %h required 0000", y); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %b required 1", in_ready); end
      exp_q.delete();
      for (int c = 0; c < 8; c++) begin
         if (c == 0) step(1'b1, 16'h0002, 16'h0003, 3'd0, 1'b0, 1'b0, 1'b1, acc, ov, got);
         else        step(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1, acc, ov, got);
         if (acc) exp_q.push_back('{16'h0005, 1'b0, 1'b0, 1'b0, 1'b0});
         if (ov) begin
            n_cmp++;
            if (c !== 2) begin n_bad++; $display("FAIL rstmid_latency: result at cycle %0d required 2", c); end
            n_cmp++;
            if (exp_q.size() == 0) begin n_bad++; $display("FAIL rstmid_stale: got y=%h from before reset", got.y); end
            else begin
               e = exp_q.pop_front();
               if (got !== e) begin n_bad++; $display("FAIL rstmid_result: got %h required %h", got, e); end
            end
            n_out++;
         end
      end
      n_cmp++; if (n_out !== 1) begin n_bad++; $display("FAIL rstmid_count: got %0d results required 1", n_out); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      op = '0;
      sgn = 1'b0;
      cin = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
